// File: rtl/ahb_lite_reg_slave_pkg.sv
// Package m14k_ahb_pkg: AHB-Lite encodings, responder FSM state codes and
// a byte-lane merge helper shared by the register slave and its bench.
package m14k_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Width of the slave's decode window inside HADDR. Bits above it belong
  // to the system decoder; anything in the window past the register bank
  // is an out-of-range access and gets an ERROR response.
  localparam int WIN_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_t;

  // Replace the byte lanes selected by strb in old with those of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_lite_reg_slave_if.sv
// AHB-Lite bus bundle between a master (or decoder + master) and the
// register slave.
//
// Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY are
// all high on a rising edge. The following cycles form its data phase,
// which ends on the first rising edge where HREADYOUT is high; HWDATA is
// consumed and HRDATA/HRESP are valid in that cycle. The master holds its
// next address phase stable while HREADY is low.
//
// Signals: HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA[31:0],
// HREADY (master -> slave); HRDATA[31:0], HREADYOUT, HRESP (slave -> master).
interface ahb_lite_reg_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_reg_slave_lane_mask.sv
// ahb_lane_mask: decodes transfer size and low address bits into the
// little-endian byte strobe, plus alignment and size error flags.
// Ports:
//   size     in  3  HSIZE of the address phase
//   addr_lo  in  2  HADDR[1:0]
//   strb     out 4  byte lanes written (bit n = HWDATA[8n+7:8n])
//   misalign out 1  half on odd address or word not on a 4-byte boundary
//   bad_size out 1  HSIZE wider than a word
module ahb_lane_mask
  import m14k_ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign,
  output logic       bad_size
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    bad_size = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
      default: bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_lite_reg_slave.sv
// ahb_lite_reg_slave: AHB-Lite responder holding a bank of 32-bit registers.
// The top register is read-only and returns ID_VALUE; register 0 is driven
// out on reg0_out. OKAY data phases insert WAIT_STATES wait cycles; bad
// accesses get a two-cycle ERROR response and never write.
// Ports:
//   SI_ClkIn        in   clock, rising edge
//   SI_ColdReset_N  in   asynchronous active-low reset
//   bus             slave modport of ahb_lite_reg_slave_if
//   reg0_out        out  live value of register 0
//   fsm_state       out  current responder state (observability)
module ahb_lite_reg_slave
  import m14k_ahb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h4D31_4B00
) (
  input  logic                  SI_ClkIn,
  input  logic                  SI_ColdReset_N,
  ahb_lite_reg_slave_if.slave   bus,
  output logic [31:0]           reg0_out,
  output ahb_state_t            fsm_state
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  ahb_state_t       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] a_idx_q;
  logic             a_write_q;
  logic [3:0]       a_strb_q;
  logic [31:0]      hrdata_q;
  logic [31:0]      regs [NUM_REGS];

  // Address-phase decode
  logic [3:0]       in_strb;
  logic             misalign, bad_size;
  logic [WIN_W-1:0] offset;
  logic [IDX_W-1:0] in_idx;
  logic             addr_err;
  logic             can_accept, accept, complete, commit;

  ahb_lane_mask u_lane_mask (
    .size     (bus.HSIZE),
    .addr_lo  (bus.HADDR[1:0]),
    .strb     (in_strb),
    .misalign (misalign),
    .bad_size (bad_size)
  );

  assign offset   = bus.HADDR[WIN_W-1:0];
  assign in_idx   = bus.HADDR[IDX_W+1:2];
  assign addr_err = (offset >= WIN_W'(NUM_REGS * 4)) | misalign | bad_size;

  // New address phases are taken only when the previous data phase is
  // finishing (or there is none); ERR1 deliberately ignores them.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                      ((state_q == ST_DATA) && (cnt_q == 3'd0));
  assign accept     = can_accept & bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign complete   = (state_q == ST_DATA) && (cnt_q == 3'd0);
  assign commit     = complete & a_write_q & (a_idx_q != ID_IDX);

  // Next state / wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2, ST_DATA: begin
        if ((state_q == ST_DATA) && (cnt_q != 3'd0)) begin
          cnt_d = cnt_q - 3'd1;
        end else if (accept && addr_err) begin
          state_d = ST_ERR1;
        end else if (accept) begin
          state_d = ST_DATA;
          cnt_d   = 3'(WAIT_STATES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      a_idx_q   <= '0;
      a_write_q <= 1'b0;
      a_strb_q  <= 4'b0000;
    end else if (accept) begin
      a_idx_q   <= in_idx;
      a_write_q <= bus.HWRITE;
      a_strb_q  <= in_strb;
    end
  end

  // Read data is registered on the edge that enters the completing cycle.
  // With zero wait states that is the address-phase edge itself, which can
  // coincide with a write committing to the same register, so the write
  // data is forwarded into the read path.
  logic [31:0]      wr_word, rd_word;
  logic [IDX_W-1:0] rd_idx;
  logic             load_rd;

  assign wr_word = merge_bytes(regs[a_idx_q], bus.HWDATA, a_strb_q);
  assign rd_idx  = accept ? in_idx : a_idx_q;
  assign load_rd = (state_d == ST_DATA) && (cnt_d == 3'd0) &&
                   (accept ? !bus.HWRITE : !a_write_q);

  always_comb begin
    rd_word = regs[rd_idx];
    if (rd_idx == ID_IDX) rd_word = ID_VALUE;
    else if (commit && (a_idx_q == rd_idx)) rd_word = wr_word;
  end

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) hrdata_q <= '0;
    else                 hrdata_q <= load_rd ? rd_word : 32'h0;
  end

  // The top entry is never written; reads of it are served by ID_VALUE.
  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (commit && (a_idx_q == IDX_W'(i))) regs[i] <= wr_word;
      end
    end
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    case (state_q)
      ST_DATA: bus.HREADYOUT = (cnt_q == 3'd0);
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
      end
      ST_ERR2: bus.HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign bus.HRDATA = hrdata_q;
  assign reg0_out   = regs[0];
  assign fsm_state  = state_q;

  // Decoder-owned address bits and the BUSY/SEQ distinction are not needed.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:WIN_W], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
module tb_ahb_lite_reg_slave;
  import m14k_ahb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared master signals; tgt steers HSEL to dut0 (0 wait) or dut1 (3 wait)
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        tgt = 1'b0;

  ahb_lite_reg_slave_if bus0();
  ahb_lite_reg_slave_if bus1();

  assign bus0.HSEL   = m_hsel & ~tgt;
  assign bus0.HADDR  = m_haddr;
  assign bus0.HTRANS = m_htrans;
  assign bus0.HWRITE = m_hwrite;
  assign bus0.HSIZE  = m_hsize;
  assign bus0.HWDATA = m_hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus1.HSEL   = m_hsel & tgt;
  assign bus1.HADDR  = m_haddr;
  assign bus1.HTRANS = m_htrans;
  assign bus1.HWRITE = m_hwrite;
  assign bus1.HSIZE  = m_hsize;
  assign bus1.HWDATA = m_hwdata;
  assign bus1.HREADY = bus1.HREADYOUT;

  logic [31:0] reg0_0, reg0_1;
  ahb_state_t  st0, st1;

  ahb_lite_reg_slave #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(32'h4D31_4B00)) dut0 (
    .SI_ClkIn(clk), .SI_ColdReset_N(rst_n), .bus(bus0.slave),
    .reg0_out(reg0_0), .fsm_state(st0)
  );

  ahb_lite_reg_slave #(.NUM_REGS(16), .WAIT_STATES(3), .ID_VALUE(32'h4D31_4B00)) dut1 (
    .SI_ClkIn(clk), .SI_ColdReset_N(rst_n), .bus(bus1.slave),
    .reg0_out(reg0_1), .fsm_state(st1)
  );

  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;
  assign cur_ready = tgt ? bus1.HREADYOUT : bus0.HREADYOUT;
  assign cur_resp  = tgt ? bus1.HRESP     : bus0.HRESP;
  assign cur_rdata = tgt ? bus1.HRDATA    : bus0.HRDATA;

  // ---------------- checking ----------------
  int check_cnt = 0;
  int err_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    m_hsel   = 1'b0;
    m_htrans = HTRANS_IDLE;
    m_hwrite = 1'b0;
    m_hsize  = HSIZE_WORD;
    m_haddr  = 32'h0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    m_hsel   = 1'b1;
    m_htrans = HTRANS_NONSEQ;
    m_hwrite = wr;
    m_haddr  = addr;
    m_hsize  = size;
  endtask

  // Waits (bounded) for the current data phase to complete; returns at the
  // negedge of the completing cycle. Wait cycles must show HRDATA = 0.
  task automatic wait_ready(output int waits, output logic first_resp);
    waits = 0;
    first_resp = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) first_resp = cur_resp;
      if (cur_ready) return;
      check_eq("wait_rdata_zero", cur_rdata, 32'h0);
      waits++;
      @(posedge clk); #1;
    end
    check_eq("ready_timeout", {31'b0, cur_ready}, 32'd1);
  endtask

  // Single non-pipelined transfer, starting and ending 1 unit after posedge.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic resp, output logic first_resp, output int waits);
    addr_phase(wr, addr, size);
    @(posedge clk); #1;
    bus_idle();
    m_hwdata = wdata;
    wait_ready(waits, first_resp);
    rdata = cur_rdata;
    resp  = cur_resp;
    @(posedge clk); #1;
    m_hwdata = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        rs, fr;
  int          w;

  initial begin
    bus_idle();
    m_hwdata = 32'h0;
    tgt = 1'b0;

    // Reset held 5 cycles
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, bus0.HREADYOUT}, 32'd1);
    check_eq("rst_resp", {31'b0, bus0.HRESP}, 32'd0);
    check_eq("rst_rdata", bus0.HRDATA, 32'h0);
    check_eq("rst_reg0", reg0_0, 32'h0);
    check_eq("rst_ready_ws3", {31'b0, bus1.HREADYOUT}, 32'd1);
    check_eq("rst_state", 32'(st0), 32'(ST_IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back word write then read of reg 0, zero wait states
    addr_phase(1'b1, 32'h0, HSIZE_WORD);
    @(posedge clk); #1;
    addr_phase(1'b0, 32'h0, HSIZE_WORD);
    m_hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("b2b_wr_ready", {31'b0, cur_ready}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    m_hwdata = 32'h0;
    @(negedge clk);
    check_eq("b2b_rd_ready", {31'b0, cur_ready}, 32'd1);
    check_eq("b2b_rd_data", cur_rdata, 32'hDEAD_BEEF);
    check_eq("b2b_rd_resp", {31'b0, cur_resp}, 32'd0);
    check_eq("b2b_reg0_out", reg0_0, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Byte and half writes into reg1
    run_xfer(1'b1, 32'h4, HSIZE_WORD, 32'h1122_3344, rd, rs, fr, w);
    run_xfer(1'b1, 32'h5, HSIZE_BYTE, 32'h0000_AA00, rd, rs, fr, w);
    check_eq("byte_wr_resp", {31'b0, rs}, 32'd0);
    run_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("byte_rd_data", rd, 32'h1122_AA44);
    check_eq("byte_rd_waits", 32'(w), 32'd0);
    run_xfer(1'b1, 32'h6, HSIZE_HALF, 32'h5566_0000, rd, rs, fr, w);
    run_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("half_rd_data", rd, 32'h5566_AA44);

    // Error responses: out of range, misaligned half, oversize
    run_xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("oor_cyc1_resp", {31'b0, fr}, 32'd1);
    check_eq("oor_cyc1_waits", 32'(w), 32'd1);
    check_eq("oor_cyc2_resp", {31'b0, rs}, 32'd1);
    run_xfer(1'b1, 32'h3, HSIZE_HALF, 32'hFFFF_FFFF, rd, rs, fr, w);
    check_eq("mis_cyc1_resp", {31'b0, fr}, 32'd1);
    check_eq("mis_cyc1_waits", 32'(w), 32'd1);
    check_eq("mis_cyc2_resp", {31'b0, rs}, 32'd1);
    check_eq("mis_reg0_kept", reg0_0, 32'hDEAD_BEEF);
    run_xfer(1'b1, 32'h0, 3'b011, 32'h0, rd, rs, fr, w);
    check_eq("size_err_resp", {31'b0, rs}, 32'd1);
    run_xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("post_err_reg0", rd, 32'hDEAD_BEEF);
    check_eq("post_err_resp", {31'b0, rs}, 32'd0);

    // Read-only ID register
    run_xfer(1'b1, 32'h3C, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("id_wr_resp", {31'b0, rs}, 32'd0);
    check_eq("id_wr_waits", 32'(w), 32'd0);
    run_xfer(1'b0, 32'h3C, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("id_rd_data", rd, 32'h4D31_4B00);

    // Three wait states
    tgt = 1'b1;
    run_xfer(1'b1, 32'h8, HSIZE_WORD, 32'h1234_5678, rd, rs, fr, w);
    check_eq("ws3_wr_waits", 32'(w), 32'd3);
    check_eq("ws3_wr_resp", {31'b0, rs}, 32'd0);
    run_xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("ws3_rd_waits", 32'(w), 32'd3);
    check_eq("ws3_rd_data", rd, 32'h1234_5678);

    // Pipelined read held through the write's wait states
    addr_phase(1'b1, 32'hC, HSIZE_WORD);
    @(posedge clk); #1;
    addr_phase(1'b0, 32'hC, HSIZE_WORD);
    m_hwdata = 32'hCAFE_F00D;
    wait_ready(w, fr);
    check_eq("pipe_wr_waits", 32'(w), 32'd3);
    @(posedge clk); #1;
    bus_idle();
    m_hwdata = 32'h0;
    wait_ready(w, fr);
    check_eq("pipe_rd_waits", 32'(w), 32'd3);
    check_eq("pipe_rd_data", cur_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset during a write wait state
    addr_phase(1'b1, 32'h10, HSIZE_WORD);
    @(posedge clk); #1;
    bus_idle();
    m_hwdata = 32'hA5A5_A5A5;
    check_eq("mid_rst_pre_state", 32'(st1), 32'(ST_DATA));
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'b0, bus1.HREADYOUT}, 32'd1);
    check_eq("mid_rst_state", 32'(st1), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_hwdata = 32'h0;
    @(posedge clk); #1;
    run_xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rs, fr, w);
    check_eq("mid_rst_no_write", rd, 32'h0);
    check_eq("mid_rst_rd_waits", 32'(w), 32'd3);
    check_eq("mid_rst_reg0_cleared", reg0_0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
